// File: rtl/mem_write_buffer.sv
`timescale 1ns/1ps
// Posted-write buffer between the L2 memory port and main memory: writes are acked
// at once and drained in the background, read misses bypass the queued writes.
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  cache_read,
  input  logic                  cache_write,
  input  logic [ADDR_W-1:0]     cache_addr,
  input  logic [DATA_W-1:0]     cache_wdata,
  output logic [DATA_W-1:0]     cache_rdata,
  output logic                  cache_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic [$clog2(DEPTH):0] buf_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {M_IDLE, M_WR, M_RD, M_GAP} mstate_e;

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  mstate_e           mstate_q, mstate_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              cache_ready_q, cache_ready_d;
  logic [DATA_W-1:0] cache_rdata_q, cache_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic             req_ok, start_wr, head_busy, pop, push;
  logic             rd_hit, wr_hit;
  logic [PTR_W-1:0] rd_hit_idx, wr_hit_idx, idx;

  assign req_ok   = !cache_ready_q && !rd_pend_q && (cache_read != cache_write);
  assign start_wr = (mstate_q == M_IDLE) && !rd_pend_q && (count_q != '0);
  // The head is off-limits for coalescing once it is (or is about to be) on the memory port.
  assign head_busy = (mstate_q == M_WR) || start_wr;
  assign pop       = (mstate_q == M_WR) && mem_ready;

  // Walk entries oldest to youngest so the last match found is the youngest.
  always_comb begin
    rd_hit     = 1'b0;
    wr_hit     = 1'b0;
    rd_hit_idx = '0;
    wr_hit_idx = '0;
    idx        = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == cache_addr)) begin
        rd_hit     = 1'b1;
        rd_hit_idx = idx;
        if (!(head_busy && (idx == head_q))) begin
          wr_hit     = 1'b1;
          wr_hit_idx = idx;
        end
      end
    end
  end

  always_comb begin
    valid_d       = valid_q;
    addr_d        = addr_q;
    data_d        = data_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    mstate_d      = mstate_q;
    rd_pend_d     = rd_pend_q;
    rd_addr_d     = rd_addr_q;
    cache_ready_d = 1'b0;
    cache_rdata_d = cache_rdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    push          = 1'b0;

    if (req_ok && cache_write) begin
      if (wr_hit) begin
        data_d[wr_hit_idx] = cache_wdata;
        cache_ready_d      = 1'b1;
      end else if ((count_q != CNT_W'(DEPTH)) || pop) begin
        push          = 1'b1;
        cache_ready_d = 1'b1;
      end
    end

    if (req_ok && cache_read) begin
      if (rd_hit) begin
        cache_rdata_d = data_q[rd_hit_idx];
        cache_ready_d = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = cache_addr;
      end
    end

    // Pop before push: when full, the incoming block lands in the slot being freed.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = cache_addr;
      data_d[tail_q]  = cache_wdata;
      tail_d          = tail_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    case (mstate_q)
      M_IDLE: begin
        if (rd_pend_q) begin
          mstate_d   = M_RD;
          mem_read_d = 1'b1;
          mem_addr_d = rd_addr_q;
        end else if (start_wr) begin
          mstate_d    = M_WR;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = data_q[head_q];
        end
      end
      M_WR: begin
        if (mem_ready) begin
          mstate_d    = M_GAP;
          mem_write_d = 1'b0;
        end
      end
      M_RD: begin
        if (mem_ready) begin
          mstate_d      = M_GAP;
          mem_read_d    = 1'b0;
          cache_rdata_d = mem_rdata;
          cache_ready_d = 1'b1;
          rd_pend_d     = 1'b0;
        end
      end
      default: mstate_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      mstate_q      <= M_IDLE;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      cache_ready_q <= 1'b0;
      cache_rdata_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      mstate_q      <= mstate_d;
      rd_pend_q     <= rd_pend_d;
      rd_addr_q     <= rd_addr_d;
      cache_ready_q <= cache_ready_d;
      cache_rdata_q <= cache_rdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign cache_ready = cache_ready_q;
  assign cache_rdata = cache_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign buf_count   = count_q;

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write buffer between the L2 cache's memory port and main memory. Absorbs L2 write-backs into a small FIFO and acknowledges them in one cycle, then drains them to memory in the background. Read misses are served from the buffer when the address is held there. Otherwise they bypass the queued writes and go to memory. Both sides use the level-held request / ready handshake already used between the cache levels and memory.

## Interface
- DEPTH, 4: number of buffer entries (power of two, ≥2)
- ADDR_W, 28: block address width
- DATA_W, 128: block data width

- clk  in  1  sole clock, rising edge
- proc_reset_n  in  1  asynchronous, active-low reset
- cache_read  in  1  read request from L2, held until cache_ready
- cache_write  in  1  write request from L2, held until cache_ready
- cache_addr  in  ADDR_W  block address
- cache_wdata  in  DATA_W  write block
- cache_rdata  out  DATA_W  read block, valid while cache_ready=1 for a read
- cache_ready  out  1  one-cycle acknowledge
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_addr  out  ADDR_W  memory block address
- mem_wdata  out  DATA_W  memory write block
- mem_rdata  in  DATA_W  memory read block, valid with mem_ready
- mem_ready  in  1  one-cycle memory acknowledge
- buf_count  out  log2(DEPTH)+1  valid entries

## Operation
- Storage: DEPTH entries of {valid, addr, data}, circular, with head/tail pointers and a count. Every output is registered.
- Request sampling: the cache request is sampled at an edge only when cache_ready=0. The cycle carrying the ack is therefore never re-accepted.
- Requests with cache_read=cache_write=1 are ignored, and cache_ready stays 0.
- Write, coalescing: if the address matches a valid entry that is not the head currently on the memory port, that entry's data is overwritten. If several entries match, the youngest is overwritten. cache_ready=1 on the next cycle.
- Write, enqueue: if no eligible match exists and count<DEPTH, the block is written at the tail. cache_ready=1 on the next cycle.
- Write, full: if count==DEPTH with no eligible match, the write waits without ack. It is enqueued at the edge where the head pops, and the count is unchanged across that edge.
- Read hit: if the address matches any valid entry, cache_rdata is set to the youngest matching data and cache_ready=1 on the next cycle. No memory access occurs.
- Read miss: the read is marked pending. The buffer waits for any in-flight memory write to complete, then issues mem_read. mem_rdata is captured on mem_ready, and cache_rdata/cache_ready are set on the following cycle.
- A pending read miss takes priority over queued writes. This is safe because a miss means no queued entry aliases the address.
- Drain engine: when count>0 and no read miss is pending or in flight, the head is issued. mem_write=1, mem_addr=head addr, mem_wdata=head data. All three are held stable until mem_ready. On mem_ready the head is popped, head advances (wrap at DEPTH) and mem_write drops.
- Memory port FSM states:
  - M_IDLE → M_WR when a drain is eligible.
  - M_IDLE → M_RD when a read miss is pending. M_RD wins if both apply.
  - M_WR → M_GAP on mem_ready.
  - M_RD → M_GAP on mem_ready.
  - M_GAP → M_IDLE after 1 cycle.
- mem_read and mem_write are never both 1.
- Reset: asynchronous clear of all entries, pointers, count, FSM and pending flag. Buffered writes are discarded; a reset mid-transaction drops the memory request immediately.
- Reset values: cache_ready=0, cache_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, buf_count=0.

## Timing
- Write ack latency: 1 cycle after request sampling when not full.
- Read hit latency: 1 cycle.
- Read miss latency:
  - 1 cycle to issue mem_read,
  - plus the wait for any in-flight write,
  - plus the memory latency,
  - plus 1 cycle from mem_ready to cache_ready.
- cache_ready is high for exactly one cycle per accepted request.
- Memory requests are deasserted the cycle after mem_ready is sampled. At least one idle cycle (M_GAP) separates consecutive memory transactions.
- Push and pop at the same edge is legal; buf_count is unchanged across it.

## Test plan
- Reset, then a write to addr 0x10 with data A: cache_ready at cycle +1, buf_count=1. mem_write to 0x10 follows with data A. After mem_ready, buf_count=0.
- Memory stalls mem_ready for 20 cycles; five writes to 0x1..0x5 with DEPTH=4: first four acked at 1-cycle latency. The fifth is acked only in the cycle after the first mem_ready. Memory then sees addresses 0x1..0x5 in order.
- Write 0x20 with data A, then 0x20 with data B while head 0x1 is in flight: only one 0x20 entry is created. Memory later receives 0x20 with data B.
- A read of 0x20 while 0x20 with data B is buffered: cache_rdata=B at +1 cycle. No mem_read is issued.
- A read miss of 0x30 with writes queued: the in-flight write completes, M_GAP follows, then mem_read at 0x30. Data from memory returns on cache_rdata. The remaining writes drain afterwards.
- Assert proc_reset_n low mid-M_WR with 3 entries: mem_write and all outputs go to 0 immediately and buf_count=0. No further memory traffic occurs after release.
